// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with synchronous clear,
// parallel load with per-digit clamping, and a wrap or saturate mode at the
// terminal value. tc is combinational so instances can be cascaded.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  load_err
);

    logic                  all_nines;
    logic                  all_zeros;
    logic                  at_terminal;
    logic [4*DIGITS-1:0]   step_q;
    logic [4*DIGITS-1:0]   clamped_value;
    logic                  load_bad;
    logic [4*DIGITS-1:0]   next_q;
    logic                  next_err;

    // Detect the two terminal patterns across all digits of the current count.
    always_comb begin
        all_nines = 1'b1;
        all_zeros = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (Q[4*k +: 4] != 4'd9) all_nines = 1'b0;
            if (Q[4*k +: 4] != 4'd0) all_zeros = 1'b0;
        end
    end

    assign at_terminal = up_down ? all_nines : all_zeros;
    assign tc          = enable & at_terminal;

    // Single-cycle ripple of carry (up) or borrow (down) from the LSD upward.
    always_comb begin
        logic       chain;
        logic [3:0] d;
        step_q = Q;
        chain  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = Q[4*k +: 4];
            if (chain) begin
                if (up_down) step_q[4*k +: 4] = (d >= 4'd9) ? 4'd0 : d + 4'd1;
                else         step_q[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            end
            chain = chain & (up_down ? (d == 4'd9) : (d == 4'd0));
        end
    end

    // Clamp any non-BCD load digit to 9 and flag that a clamp happened.
    always_comb begin
        clamped_value = load_value;
        load_bad      = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_value[4*k +: 4] > 4'd9) begin
                clamped_value[4*k +: 4] = 4'd9;
                load_bad                = 1'b1;
            end
        end
    end

    // Select the next count and error flag with clear > load > enable > hold.
    always_comb begin
        next_q   = Q;
        next_err = 1'b0;
        if (clear) begin
            next_q   = '0;
            next_err = 1'b0;
        end else if (load) begin
            next_q   = clamped_value;
            next_err = load_bad;
        end else if (enable) begin
            if (SATURATE && at_terminal) next_q = Q;
            else                         next_q = step_q;
        end
    end

    // Count and error registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q        <= '0;
            load_err <= 1'b0;
        end else begin
            Q        <= next_q;
            load_err <= next_err;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: drives a wrapping and a saturating 3-digit counter
// with shared stimulus and compares both against hand-computed vectors.
module tb_bcd_updown_counter;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic          up_down;
    logic          clear;
    logic          load;
    logic [W-1:0]  load_value;
    logic [W-1:0]  q_wrap;
    logic [W-1:0]  q_sat;
    logic          tc_wrap;
    logic          tc_sat;
    logic          err_wrap;
    logic          err_sat;

    int n_compared;
    int n_mismatched;

    typedef struct {
        bit           clear;
        bit           load;
        bit           enable;
        bit           up_down;
        logic [W-1:0] load_value;
        logic [W-1:0] q_wrap;
        logic [W-1:0] q_sat;
        bit           err;
        bit           tc_wrap;
        bit           tc_sat;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .up_down    (up_down),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .Q          (q_wrap),
        .tc         (tc_wrap),
        .load_err   (err_wrap)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .up_down    (up_down),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .Q          (q_sat),
        .tc         (tc_sat),
        .load_err   (err_sat)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit c, input bit l, input bit e, input bit u,
                                  input logic [W-1:0] lv);
        clear      = c;
        load       = l;
        enable     = e;
        up_down    = u;
        load_value = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        //                clr ld en up  load_val  q_wrap   q_sat    err tcw tcs
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h997, 12'h997, 12'h997, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h999, 12'h999, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 12'h999, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h099, 12'h099, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h098, 12'h098, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h001, 12'h001, 12'h001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h999, 12'h000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h998, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h999, 12'h999, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 12'h999, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h001, 12'h999, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h002, 12'h999, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h001, 12'h998, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h3A5, 12'h395, 12'h395, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h395, 12'h395, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h3A5, 12'h395, 12'h395, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 12'h123, 12'h123, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h777, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h777, 12'h777, 12'h777, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'hA0B, 12'h909, 12'h909, 1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h910, 12'h910, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h909, 12'h909, 1'b0, 1'b0, 1'b0};

        reset_n    = 1'b0;
        enable     = 1'b0;
        up_down    = 1'b1;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        #2;
        check_output("reset q_wrap", 32'(q_wrap), 32'h000);
        check_output("reset q_sat", 32'(q_sat), 32'h000);
        check_output("reset err_wrap", 32'(err_wrap), 32'd0);
        check_output("reset tc_wrap", 32'(tc_wrap), 32'd0);
        #10;
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].clear, vecs[i].load, vecs[i].enable, vecs[i].up_down,
                           vecs[i].load_value);
            check_output($sformatf("vec%0d q_wrap", i), 32'(q_wrap), 32'(vecs[i].q_wrap));
            check_output($sformatf("vec%0d q_sat", i), 32'(q_sat), 32'(vecs[i].q_sat));
            check_output($sformatf("vec%0d err_wrap", i), 32'(err_wrap), 32'(vecs[i].err));
            check_output($sformatf("vec%0d err_sat", i), 32'(err_sat), 32'(vecs[i].err));
            check_output($sformatf("vec%0d tc_wrap", i), 32'(tc_wrap), 32'(vecs[i].tc_wrap));
            check_output($sformatf("vec%0d tc_sat", i), 32'(tc_sat), 32'(vecs[i].tc_sat));
        end

        // Asynchronous reset in the middle of a cycle while holding 0x456.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'h456);
        check_output("preload q_wrap", 32'(q_wrap), 32'h456);
        load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async reset q_wrap", 32'(q_wrap), 32'h000);
        check_output("async reset q_sat", 32'(q_sat), 32'h000);
        check_output("async reset err", 32'(err_wrap), 32'd0);
        enable  = 1'b1;
        up_down = 1'b0;
        #1;
        check_output("reset tc down", 32'(tc_wrap), 32'd1);
        enable  = 1'b0;
        up_down = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
            check_output($sformatf("post reset hold%0d", i), 32'(q_wrap), 32'h000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
